// File: rtl/rv32_pkg.sv
// Shared rv32 core types and constants.
// Imported by every pipeline stage of the core.
package rv32_pkg;

    localparam int XPR_LEN = 32;

    typedef logic [31:0]        rv32_instr_t;
    typedef logic [XPR_LEN-1:0] rv32_addr_t;

    localparam rv32_instr_t RV32_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } rv32_fetch_state_e;

    typedef struct packed {
        rv32_addr_t  pc;
        rv32_instr_t instr;
    } rv32_fetch_entry_t;

    function automatic rv32_addr_t rv32_word_align(input rv32_addr_t a);
        return {a[XPR_LEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv32_fetch_fifo.sv
// Parameterised synchronous FIFO with flush, used by the fetch stage
// for both the prefetch buffer and the in-flight PC queue.
module rv32_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rv32_fetch_unit.sv
// rv32 instruction fetch stage: credit-limited imem requests feeding a
// prefetch FIFO that hands {pc, instr} to decode; redirects drop stale data.
module rv32_fetch_unit
    import rv32_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter rv32_addr_t RESET_PC   = 32'h0000_0000
) (
    input  logic               rv32_clk,
    input  logic               rv32_rst_n,
    input  logic               redirect_valid,
    input  logic [XPR_LEN-1:0] redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XPR_LEN-1:0] imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [31:0]        imem_rsp_data,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [31:0]        dec_instr,
    output logic [XPR_LEN-1:0] dec_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = $bits(rv32_fetch_entry_t);

    rv32_fetch_state_e state_q;
    rv32_fetch_state_e state_d;

    rv32_addr_t        fetch_pc_q;
    logic [CW-1:0]     drop_cnt_q;
    logic [CW-1:0]     drop_cnt_d;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_left;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_used;

    logic              pcq_full;
    logic              pcq_empty;
    logic              fifo_full;
    logic              fifo_empty;
    rv32_addr_t        pcq_head;
    logic [EW-1:0]     fifo_head_raw;
    rv32_fetch_entry_t fifo_head;
    rv32_fetch_entry_t push_entry;
    rv32_fetch_entry_t hold_q;

    logic              req_fire;
    logic              rsp_fire;
    logic              fifo_push;
    logic              fifo_pop;
    logic              can_issue;
    logic              fetch_active;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && !pcq_empty;

    assign outstanding_left = outstanding - CW'(rsp_fire);

    // Every in-flight request owns a FIFO slot, so responses never stall.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign can_issue   = !pcq_full && !fifo_full
                      && (credit_used < (CW+1)'(FIFO_DEPTH));

    assign fifo_push  = rsp_fire && !redirect_valid && (drop_cnt_q == '0);
    assign fifo_pop   = dec_valid && dec_ready && !redirect_valid;
    assign push_entry = '{pc: pcq_head, instr: imem_rsp_data};
    assign fifo_head  = rv32_fetch_entry_t'(fifo_head_raw);

    always_ff @(posedge rv32_clk) begin
        if (!rv32_rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_valid && (outstanding_left != '0)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!redirect_valid && (drop_cnt_d == '0)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_comb begin
        fetch_active   = (state_q == RUN) || (state_q == FLUSH);
        imem_req_valid = fetch_active && !redirect_valid && can_issue;
    end

    // The redirect-cycle response is discarded outright, not counted.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            drop_cnt_d = outstanding_left;
        end else if (rsp_fire && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge rv32_clk) begin
        if (!rv32_rst_n) begin
            fetch_pc_q   <= RESET_PC;
            drop_cnt_q   <= '0;
            hold_q.pc    <= '0;
            hold_q.instr <= RV32_NOP_INSTR;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            if (redirect_valid) begin
                fetch_pc_q <= rv32_word_align(redirect_pc);
            end else if (req_fire) begin
                fetch_pc_q <= fetch_pc_q + XPR_LEN'(4);
            end
            if (!fifo_empty) begin
                hold_q <= fifo_head;
            end
        end
    end

    assign imem_req_addr = fetch_pc_q;
    assign dec_valid     = !fifo_empty;
    assign dec_pc        = fifo_empty ? hold_q.pc    : fifo_head.pc;
    assign dec_instr     = fifo_empty ? hold_q.instr : fifo_head.instr;

    // In-flight PCs; its occupancy is the outstanding-request count.
    rv32_fetch_fifo #(
        .WIDTH (XPR_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk       (rv32_clk),
        .rst_n     (rv32_rst_n),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (rsp_fire),
        .pop_data  (pcq_head),
        .count     (outstanding),
        .full      (pcq_full),
        .empty     (pcq_empty)
    );

    rv32_fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch (
        .clk       (rv32_clk),
        .rst_n     (rv32_rst_n),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_head_raw),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
